// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration-chain loader.
//   BYTE_W      : width of the bitstream and readback byte streams.
//   cfg_state_e : loader FSM states.
package fpga_cfg_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_FLUSH,
    ST_DONE
  } cfg_state_e;

endpackage

// File: rtl/ccff_rb_packer.sv
// Readback byte assembler: collects serial bits MSB first into a byte and
// presents it on a valid/ready interface. A flush marks the last bit of the
// chain so that a partial byte is emitted, zero-padded in its LSBs.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clr_i           : synchronous clear (load aborted)
//   bit_i/bit_vld_i : serial input bit and its qualifier
//   flush_i         : with bit_vld_i, this bit closes the current byte
//   rb_valid_o/rb_ready_i/rb_data_o : byte output stream
module ccff_rb_packer
  import fpga_cfg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              bit_i,
  input  logic              bit_vld_i,
  input  logic              flush_i,
  input  logic              rb_ready_i,
  output logic              rb_valid_o,
  output logic [BYTE_W-1:0] rb_data_o
);

  logic [BYTE_W-1:0] acc_q, acc_d, acc_next;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    data_d   = data_q;
    acc_next = {acc_q[BYTE_W-2:0], bit_i};
    if (vld_q && rb_ready_i) begin
      vld_d = 1'b0;
    end
    // A completing bit can coincide with the handshake of the previous byte;
    // the new byte wins so nothing is lost.
    if (bit_vld_i) begin
      if (cnt_q == 3'd7 || flush_i) begin
        data_d = acc_next << (3'd7 - cnt_q);
        vld_d  = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign rb_valid_o = vld_q;
  assign rb_data_o  = data_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a configuration bitstream into a downstream ccff scan chain.
// Bytes arrive on in_valid/in_ready/in_data and are shifted MSB first onto
// ccff_head; ccff_clk_en enables the external clock gate of the chain for
// exactly CHAIN_LEN edges per load. Old chain contents coming back on
// ccff_tail are optionally packed into bytes on rb_valid/rb_ready/rb_data.
// Ports:
//   prog_clk, pReset     : clock, synchronous active-high reset
//   cfg_start, cfg_abort : begin a load (IDLE only) / cancel a load
//   in_valid/in_ready/in_data : bitstream input stream
//   ccff_head, ccff_clk_en, ccff_tail : chain interface
//   rb_valid/rb_ready/rb_data : readback output stream
//   cfg_busy, cfg_done   : not-idle flag / completion pulse
module ccff_bitstream_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int RB_EN     = 1
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [BYTE_W-1:0] rb_data,
  output logic              cfg_busy,
  output logic              cfg_done
);

  localparam int              CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  cfg_state_e        state_q, state_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        sub_cnt_q, sub_cnt_d;
  logic              stall, shift_en, last_bit, aborting, rb_vld_int;

  // Only a pending, unaccepted readback byte can hold the chain.
  assign stall    = (RB_EN != 0) && rb_vld_int && !rb_ready;
  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign aborting = cfg_abort && (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    in_ready    = 1'b0;
    ccff_head   = 1'b0;
    ccff_clk_en = 1'b0;
    shift_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d   = ST_FETCH;
          bit_cnt_d = '0;
        end
      end
      ST_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d   = in_data;
          sub_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ccff_head = shreg_q[BYTE_W-1];
        if (!stall) begin
          ccff_clk_en = 1'b1;
          shift_en    = 1'b1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          shreg_d     = {shreg_q[BYTE_W-2:0], 1'b0};
          sub_cnt_d   = sub_cnt_q + 3'd1;
          // The chain length ends the load even mid-byte; leftover bits of
          // the final byte are simply dropped.
          if (last_bit) begin
            state_d = ST_FLUSH;
          end else if (sub_cnt_q == 3'd7) begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FLUSH: begin
        if (!rb_vld_int) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (aborting) begin
      state_d     = ST_IDLE;
      ccff_clk_en = 1'b0;
      shift_en    = 1'b0;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sub_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sub_cnt_q <= sub_cnt_d;
    end
  end

  // Byte shift register is pure data; ccff_head is masked outside SHIFT.
  always_ff @(posedge prog_clk) begin
    shreg_q <= shreg_d;
  end

  ccff_rb_packer u_rb_packer (
    .clk_i      (prog_clk),
    .rst_i      (pReset),
    .clr_i      (aborting),
    .bit_i      (ccff_tail),
    .bit_vld_i  (shift_en && (RB_EN != 0)),
    .flush_i    (last_bit),
    .rb_ready_i (rb_ready),
    .rb_valid_o (rb_vld_int),
    .rb_data_o  (rb_data)
  );

  assign rb_valid = rb_vld_int;
  assign cfg_busy = (state_q != ST_IDLE);
  assign cfg_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench for ccff_bitstream_loader. Three instances cover
// CHAIN_LEN=8/RB_EN=0, CHAIN_LEN=12/RB_EN=1 and CHAIN_LEN=8/RB_EN=1; one is
// selected at a time and a shared chain model shifts on its clock enable.
module tb_ccff_bitstream_loader;

  logic        prog_clk = 1'b0;
  logic        pReset, cfg_start, cfg_abort, in_valid, rb_ready;
  logic [7:0]  in_data;
  logic [1:0]  sel;

  logic [2:0]  start_w, in_ready_w, head_w, clk_en_w, tail_w, rb_valid_w, busy_w, done_w;
  logic [7:0]  rb_data_w [3];

  logic        obs_in_ready, obs_head, obs_clk_en, obs_rb_valid, obs_busy, obs_done;
  logic [7:0]  obs_rb_data;

  logic [15:0] chain, preload_v;
  logic        load_req;

  int          checks, failures;
  int          en_cnt, rdy_cnt, rb_n, done_cnt, feed_idx;
  logic [15:0] heads;
  logic [7:0]  rb_log [4];
  logic [7:0]  feed_b [2];

  always #5 prog_clk = ~prog_clk;

  assign start_w[0] = cfg_start && (sel == 2'd0);
  assign start_w[1] = cfg_start && (sel == 2'd1);
  assign start_w[2] = cfg_start && (sel == 2'd2);
  assign tail_w[0]  = chain[7];
  assign tail_w[1]  = chain[11];
  assign tail_w[2]  = chain[7];

  ccff_bitstream_loader #(.CHAIN_LEN(8), .RB_EN(0)) u_a (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(start_w[0]), .cfg_abort(cfg_abort),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
    .ccff_head(head_w[0]), .ccff_clk_en(clk_en_w[0]), .ccff_tail(tail_w[0]),
    .rb_valid(rb_valid_w[0]), .rb_ready(rb_ready), .rb_data(rb_data_w[0]),
    .cfg_busy(busy_w[0]), .cfg_done(done_w[0]));

  ccff_bitstream_loader #(.CHAIN_LEN(12), .RB_EN(1)) u_b (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(start_w[1]), .cfg_abort(cfg_abort),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
    .ccff_head(head_w[1]), .ccff_clk_en(clk_en_w[1]), .ccff_tail(tail_w[1]),
    .rb_valid(rb_valid_w[1]), .rb_ready(rb_ready), .rb_data(rb_data_w[1]),
    .cfg_busy(busy_w[1]), .cfg_done(done_w[1]));

  ccff_bitstream_loader #(.CHAIN_LEN(8), .RB_EN(1)) u_c (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(start_w[2]), .cfg_abort(cfg_abort),
    .in_valid(in_valid), .in_ready(in_ready_w[2]), .in_data(in_data),
    .ccff_head(head_w[2]), .ccff_clk_en(clk_en_w[2]), .ccff_tail(tail_w[2]),
    .rb_valid(rb_valid_w[2]), .rb_ready(rb_ready), .rb_data(rb_data_w[2]),
    .cfg_busy(busy_w[2]), .cfg_done(done_w[2]));

  always_comb begin
    obs_in_ready = 1'b0; obs_head = 1'b0; obs_clk_en = 1'b0;
    obs_rb_valid = 1'b0; obs_busy = 1'b0; obs_done = 1'b0; obs_rb_data = 8'h00;
    case (sel)
      2'd0: begin
        obs_in_ready = in_ready_w[0]; obs_head = head_w[0]; obs_clk_en = clk_en_w[0];
        obs_rb_valid = rb_valid_w[0]; obs_busy = busy_w[0]; obs_done = done_w[0];
        obs_rb_data = rb_data_w[0];
      end
      2'd1: begin
        obs_in_ready = in_ready_w[1]; obs_head = head_w[1]; obs_clk_en = clk_en_w[1];
        obs_rb_valid = rb_valid_w[1]; obs_busy = busy_w[1]; obs_done = done_w[1];
        obs_rb_data = rb_data_w[1];
      end
      default: begin
        obs_in_ready = in_ready_w[2]; obs_head = head_w[2]; obs_clk_en = clk_en_w[2];
        obs_rb_valid = rb_valid_w[2]; obs_busy = busy_w[2]; obs_done = done_w[2];
        obs_rb_data = rb_data_w[2];
      end
    endcase
  end

  // Chain model: the tail of the selected chain length feeds back to the DUT.
  always @(posedge prog_clk) begin
    if (load_req) chain <= preload_v;
    else if (obs_clk_en) chain <= {chain[14:0], obs_head};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, then advance the byte feed after the edge.
  task automatic cyc();
    logic hs;
    @(negedge prog_clk);
    if (obs_clk_en) begin heads = {heads[14:0], obs_head}; en_cnt++; end
    if (obs_in_ready) rdy_cnt++;
    if (obs_rb_valid && rb_ready) begin
      if (rb_n < 4) rb_log[rb_n] = obs_rb_data;
      rb_n++;
    end
    if (obs_done) done_cnt++;
    hs = obs_in_ready && in_valid;
    @(posedge prog_clk); #1;
    if (hs && feed_idx < 1) begin
      feed_idx++;
      in_data = feed_b[feed_idx];
    end
  endtask

  task automatic begin_load(input logic [1:0] s, input logic [15:0] pre,
                            input logic [7:0] b0, input logic [7:0] b1);
    sel = s; preload_v = pre; load_req = 1'b1;
    en_cnt = 0; rdy_cnt = 0; rb_n = 0; done_cnt = 0; heads = '0;
    for (int k = 0; k < 4; k++) rb_log[k] = 8'h00;
    feed_b[0] = b0; feed_b[1] = b1; feed_idx = 0;
    in_data = b0; in_valid = 1'b1;
    @(posedge prog_clk); #1;
    load_req = 1'b0; cfg_start = 1'b1;
    @(posedge prog_clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic finish_load(input string name);
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (done_cnt > 0) break;
    end
    chk({name, ".done_pulse"}, done_cnt, 1);
    @(negedge prog_clk);
    chk({name, ".busy_after"}, obs_busy, 1'b0);
    chk({name, ".done_after"}, obs_done, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge prog_clk);
    chk({name, ".in_ready"}, obs_in_ready, 1'b0);
    chk({name, ".ccff_head"}, obs_head, 1'b0);
    chk({name, ".ccff_clk_en"}, obs_clk_en, 1'b0);
    chk({name, ".rb_valid"}, obs_rb_valid, 1'b0);
    chk({name, ".rb_data"}, obs_rb_data, 8'h00);
    chk({name, ".cfg_busy"}, obs_busy, 1'b0);
    chk({name, ".cfg_done"}, obs_done, 1'b0);
  endtask

  // Readback with rb_ready held low for six cycles once rb_valid appears.
  task automatic run_stall(input string name, input logic [1:0] s, input logic [15:0] pre,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] exp_rb0, input int exp_en_total);
    int bad, en_at;
    rb_ready = 1'b0;
    begin_load(s, pre, b0, b1);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (obs_rb_valid) break;
    end
    chk({name, ".rb_valid_seen"}, obs_rb_valid, 1'b1);
    en_at = en_cnt;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (obs_rb_valid !== 1'b1 || obs_rb_data !== exp_rb0 || obs_busy !== 1'b1) bad++;
    end
    chk({name, ".held_stable"}, bad, 0);
    chk({name, ".bits_before_stall"}, en_at, 8);
    chk({name, ".no_shift_in_stall"}, en_cnt, en_at);
    rb_ready = 1'b1;
    finish_load(name);
    chk({name, ".enabled_total"}, en_cnt, exp_en_total);
    chk({name, ".rb0"}, rb_log[0], exp_rb0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [7:0]  b0, b1;
    logic [15:0] pre, heads;
    int          n_en, n_rdy, n_rb;
    logic [7:0]  rb0, rb1;
  } vec_t;

  vec_t vecs [5];
  int   lens [3];

  initial begin
    vecs[0] = '{"a5_len8_norb",  2'd0, 8'hA5, 8'h00, 16'h00FF, 16'h00A5, 8,  1, 0, 8'h00, 8'h00};
    vecs[1] = '{"f03_len12",     2'd1, 8'hF0, 8'h3C, 16'h0ABC, 16'h0F03, 12, 2, 2, 8'hAB, 8'hC0};
    vecs[2] = '{"5a_len8_rb",    2'd2, 8'h5A, 8'h00, 16'h0096, 16'h005A, 8,  1, 1, 8'h96, 8'h00};
    vecs[3] = '{"123_len12",     2'd1, 8'h12, 8'h34, 16'h05A5, 16'h0123, 12, 2, 2, 8'h5A, 8'h50};
    vecs[4] = '{"ff_len8_norb",  2'd0, 8'hFF, 8'h00, 16'h0000, 16'h00FF, 8,  1, 0, 8'h00, 8'h00};
    lens[0] = 8; lens[1] = 12; lens[2] = 8;

    checks = 0; failures = 0;
    pReset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; in_valid = 1'b0; rb_ready = 1'b1;
    in_data = 8'h00; sel = 2'd2; load_req = 1'b0; preload_v = '0;
    en_cnt = 0; rdy_cnt = 0; rb_n = 0; done_cnt = 0; feed_idx = 0; heads = '0;
    repeat (2) @(posedge prog_clk);
    #1 pReset = 1'b0;
    check_reset_outputs("reset");

    for (int v = 0; v < 5; v++) begin
      logic [15:0] mask;
      rb_ready = 1'b1;
      begin_load(vecs[v].sel, vecs[v].pre, vecs[v].b0, vecs[v].b1);
      finish_load(vecs[v].name);
      mask = 16'((32'd1 << lens[vecs[v].sel]) - 1);
      chk({vecs[v].name, ".head_seq"}, heads & mask, vecs[v].heads);
      chk({vecs[v].name, ".enabled"}, en_cnt, vecs[v].n_en);
      chk({vecs[v].name, ".in_ready_cycles"}, rdy_cnt, vecs[v].n_rdy);
      chk({vecs[v].name, ".chain_contents"}, chain & mask, vecs[v].heads);
      chk({vecs[v].name, ".rb_count"}, rb_n, vecs[v].n_rb);
      if (vecs[v].n_rb > 0) chk({vecs[v].name, ".rb0"}, rb_log[0], vecs[v].rb0);
      if (vecs[v].n_rb > 1) chk({vecs[v].name, ".rb1"}, rb_log[1], vecs[v].rb1);
    end

    // Stall mid-chain (between bytes) and stall at the end of the chain.
    run_stall("stall_len12", 2'd1, 16'h0ABC, 8'hF0, 8'h3C, 8'hAB, 12);
    chk("stall_len12.rb1", rb_log[1], 8'hC0);
    run_stall("stall_len8", 2'd2, 16'h0096, 8'h00, 8'h00, 8'h96, 8);

    // Abort after three shifted bits, then a clean restart.
    rb_ready = 1'b1;
    begin_load(2'd2, 16'h0000, 8'hFF, 8'h00);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (en_cnt >= 3) break;
    end
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
    @(negedge prog_clk);
    chk("abort.busy", obs_busy, 1'b0);
    chk("abort.rb_valid", obs_rb_valid, 1'b0);
    chk("abort.clk_en", obs_clk_en, 1'b0);
    repeat (3) cyc();
    chk("abort.enabled", en_cnt, 3);
    chk("abort.no_done", done_cnt, 0);
    begin_load(2'd2, 16'h0000, 8'hA5, 8'h00);
    finish_load("restart");
    chk("restart.enabled", en_cnt, 8);
    chk("restart.head_seq", heads & 16'h00FF, 16'h00A5);

    // cfg_start together with cfg_abort in IDLE stays idle.
    @(posedge prog_clk); #1;
    sel = 2'd2; cfg_start = 1'b1; cfg_abort = 1'b1;
    @(posedge prog_clk); #1;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    @(negedge prog_clk);
    chk("start_abort_idle.busy", obs_busy, 1'b0);
    chk("start_abort_idle.in_ready", obs_in_ready, 1'b0);

    // Reset while FETCH waits on in_valid.
    begin_load(2'd2, 16'h0000, 8'h77, 8'h00);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("fetch_wait.busy", obs_busy, 1'b1);
    chk("fetch_wait.in_ready", obs_in_ready, 1'b1);
    pReset = 1'b1;
    cyc();
    pReset = 1'b0;
    check_reset_outputs("reset_in_fetch");

    // cfg_start pulsed mid-load must not disturb the bit count.
    begin_load(2'd2, 16'h0000, 8'h3C, 8'h00);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (en_cnt >= 3) break;
    end
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    finish_load("start_while_busy");
    chk("start_while_busy.enabled", en_cnt, 8);
    chk("start_while_busy.head_seq", heads & 16'h00FF, 16'h003C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
